// File: rtl/sw_pkg.sv
// Shared switch/NI definitions: flit type encoding, default flit width and
// small helpers that slice a flit into its type and payload fields.
// Used by the receive network interface and the other switch-side blocks.
package sw_pkg;

  // Default flit width: 2 type bits plus an 8-bit payload.
  localparam int DW_DEF = 10;

  typedef enum logic [1:0] {
    FT_EMPTY = 2'b00,
    FT_HEAD  = 2'b01,
    FT_BODY  = 2'b10,
    FT_TAIL  = 2'b11
  } flit_type_t;

  // Convert the two type bits at the top of a flit into the enum.
  function automatic flit_type_t flit_type(input logic [1:0] tbits);
    return flit_type_t'(tbits);
  endfunction

  // True when the type bits mark a tail flit.
  function automatic logic is_tail(input logic [1:0] tbits);
    return flit_type_t'(tbits) == FT_TAIL;
  endfunction

endpackage

// File: rtl/ni_rx_buf.sv
// Packet reassembly buffer for the receive network interface.
// A circular flit memory with three pointers:
//   rd     - head of the committed data seen by the core
//   commit - end of the last complete packet; data beyond it is invisible
//   wr     - next write slot; may run ahead of commit with a partial packet
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   wr_en, wr_data    write one flit (caller guarantees free != 0)
//   rewind            discard the partial packet (wr <- commit); a write in
//                     the same cycle lands at the old commit position
//   commit            the flit written this cycle closes a packet
//   pop               core consumed the head flit
//   free              free slots, from registered pointers only
//   rd_data           flit at rd (combinational read)
//   rd_valid          committed data available (rd != commit)
module ni_rx_buf #(
  parameter int DW    = 10,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rewind,
  input  logic          commit,
  input  logic          pop,
  output logic [$clog2(DEPTH):0] free,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DW-1:0] mem [DEPTH];

  logic [PW-1:0] rd_reg, wr_reg, commit_reg;
  logic [PW-1:0] rd_next, wr_next, commit_next;
  logic [PW-1:0] wr_base;

  // A rewind moves the write position back to the last packet boundary
  // before any write of this cycle is placed.
  assign wr_base = rewind ? commit_reg : wr_reg;

  always_comb begin
    wr_next     = wr_base + PW'(wr_en);
    rd_next     = rd_reg + PW'(pop);
    commit_next = commit_reg;
    if (commit) begin
      commit_next = wr_base + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_reg     <= '0;
      wr_reg     <= '0;
      commit_reg <= '0;
    end else begin
      rd_reg     <= rd_next;
      wr_reg     <= wr_next;
      commit_reg <= commit_next;
    end
  end

  // Storage carries no reset: stale slots are never exposed because
  // visibility is governed purely by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_base[AW-1:0]] <= wr_data;
    end
  end

  // Pointer difference is modulo 2*DEPTH, so it is exact even after wrap.
  assign free     = PW'(DEPTH) - (wr_reg - rd_reg);
  assign rd_data  = mem[rd_reg[AW-1:0]];
  assign rd_valid = (rd_reg != commit_reg);

endmodule

// File: rtl/ni_rx.sv
// Receive-side network interface for one switch output port.
// Reassembles packets from the switch flit stream into ni_rx_buf and
// presents only complete packets to the core over valid/ready. The switch
// cannot be stalled, so a packet that does not fit, is too long, or is
// malformed is dropped as a whole.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   in_flit       flit from the switch, sampled every cycle
//   out_flit      flit at buffer head, type bits included
//   out_valid     out_flit belongs to a committed packet
//   out_last      out_flit is a tail flit (qualified by out_valid)
//   out_ready     core accepts out_flit
//   pkt_cnt       committed packets, wraps
//   drop_cnt      dropped packets, saturates at 255
//   err           sticky protocol error
module ni_rx
  import sw_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int DEPTH  = 16,
  parameter int MAXLEN = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_flit,
  output logic [DW-1:0] out_flit,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready,
  output logic [15:0]   pkt_cnt,
  output logic [7:0]    drop_cnt,
  output logic          err
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int LW = $clog2(MAXLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [LW-1:0] len_reg, len_next;
  logic [15:0]   pkt_cnt_reg, pkt_cnt_next;
  logic [7:0]    drop_cnt_reg, drop_cnt_next;
  logic          err_reg, err_next;

  logic          wr_en, rewind, commit, pop;
  logic          take_head, err_set, pkt_inc;
  logic [1:0]    drop_inc;
  logic [8:0]    drop_sum;
  logic [PW-1:0] free;
  logic          has_space;
  logic          buf_valid;
  flit_type_t    ftype;

  assign ftype     = flit_type(in_flit[DW-1 -: 2]);
  assign has_space = (free != '0);
  assign pop       = buf_valid & out_ready;

  ni_rx_buf #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (in_flit),
    .rewind   (rewind),
    .commit   (commit),
    .pop      (pop),
    .free     (free),
    .rd_data  (out_flit),
    .rd_valid (buf_valid)
  );

  assign out_valid = buf_valid;
  assign out_last  = is_tail(out_flit[DW-1 -: 2]);

  // Next-state and control strobes.
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    wr_en      = 1'b0;
    rewind     = 1'b0;
    commit     = 1'b0;
    take_head  = 1'b0;
    err_set    = 1'b0;
    pkt_inc    = 1'b0;
    drop_inc   = 2'd0;

    case (state_reg)
      S_IDLE: begin
        case (ftype)
          FT_HEAD:         take_head = 1'b1;
          FT_BODY, FT_TAIL: err_set  = 1'b1;
          default:         ;
        endcase
      end

      S_RECV: begin
        case (ftype)
          FT_HEAD: begin
            // Abandon the open packet and start over with this head.
            rewind    = 1'b1;
            err_set   = 1'b1;
            drop_inc  = 2'd1;
            take_head = 1'b1;
          end
          FT_BODY, FT_TAIL: begin
            if (!has_space) begin
              rewind     = 1'b1;
              drop_inc   = 2'd1;
              state_next = S_DROP;
            end else if (ftype == FT_BODY) begin
              // A body at MAXLEN-1 leaves no room for the tail.
              if (len_reg == LW'(MAXLEN - 1)) begin
                rewind     = 1'b1;
                drop_inc   = 2'd1;
                err_set    = 1'b1;
                state_next = S_DROP;
              end else begin
                wr_en    = 1'b1;
                len_next = len_reg + LW'(1);
              end
            end else begin
              wr_en      = 1'b1;
              commit     = 1'b1;
              pkt_inc    = 1'b1;
              len_next   = '0;
              state_next = S_IDLE;
            end
          end
          default: ;
        endcase
      end

      S_DROP: begin
        case (ftype)
          FT_TAIL: state_next = S_IDLE;
          FT_HEAD: begin
            err_set   = 1'b1;
            take_head = 1'b1;
          end
          default: ;
        endcase
      end

      default: state_next = S_IDLE;
    endcase

    // Shared head handling; space is judged on the registered pointers, so
    // a same-cycle rewind does not make room for this head.
    if (take_head) begin
      if (has_space) begin
        wr_en      = 1'b1;
        len_next   = LW'(1);
        state_next = S_RECV;
      end else begin
        drop_inc   = drop_inc + 2'd1;
        state_next = S_DROP;
      end
    end
  end

  // Counter updates; a HEAD that aborts one packet and is itself dropped
  // can add two to drop_cnt in a single cycle.
  always_comb begin
    pkt_cnt_next  = pkt_cnt_reg + 16'(pkt_inc);
    drop_sum      = {1'b0, drop_cnt_reg} + 9'(drop_inc);
    drop_cnt_next = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
    err_next      = err_reg | err_set;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      len_reg      <= '0;
      pkt_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      pkt_cnt_reg  <= pkt_cnt_next;
      drop_cnt_reg <= drop_cnt_next;
      err_reg      <= err_next;
    end
  end

  assign pkt_cnt  = pkt_cnt_reg;
  assign drop_cnt = drop_cnt_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_ni_rx.sv
// Bench for ni_rx: directed scenarios followed by random traffic, all
// checked every cycle against a packet-level reference model built from
// queues of committed and partial flits.
module tb_ni_rx;
  import sw_pkg::*;

  localparam int DW     = 10;
  localparam int DEPTH  = 16;
  localparam int MAXLEN = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] in_flit = '0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_flit;
  logic          out_valid;
  logic          out_last;
  logic [15:0]   pkt_cnt;
  logic [7:0]    drop_cnt;
  logic          err;

  ni_rx #(.DW(DW), .DEPTH(DEPTH), .MAXLEN(MAXLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .pkt_cnt   (pkt_cnt),
    .drop_cnt  (drop_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: committed flits visible to the core, the packet
  // currently being assembled, and a simple mode flag.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] part_q[$];
  int m_mode;          // 0 waiting for head, 1 assembling, 2 discarding
  int m_pkt;
  int m_drop;
  logic m_err;

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [7:0] p);
    return {t, p};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bump_drop();
    if (m_drop < 255) m_drop++;
  endtask

  task automatic model_head(input logic [DW-1:0] f, input int free);
    part_q.delete();
    if (free > 0) begin
      part_q.push_back(f);
      m_mode = 1;
    end else begin
      bump_drop();
      m_mode = 2;
    end
  endtask

  task automatic model_edge(input logic [DW-1:0] f, input logic rdy, input logic rv);
    int free;
    logic [1:0] t;
    if (!rv) begin
      exp_q.delete(); part_q.delete();
      m_mode = 0; m_pkt = 0; m_drop = 0; m_err = 1'b0;
      return;
    end
    // Space seen this cycle excludes anything popped in the same cycle.
    free = DEPTH - (exp_q.size() + part_q.size());
    if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
    t = f[DW-1 -: 2];
    if (t == 2'b00) return;
    if (m_mode == 0) begin
      if (t == 2'b01) model_head(f, free);
      else m_err = 1'b1;
    end else if (m_mode == 1) begin
      if (t == 2'b01) begin
        part_q.delete(); m_err = 1'b1; bump_drop();
        model_head(f, free);
      end else if (free == 0) begin
        part_q.delete(); bump_drop(); m_mode = 2;
      end else if (t == 2'b10) begin
        if (part_q.size() == MAXLEN - 1) begin
          part_q.delete(); bump_drop(); m_err = 1'b1; m_mode = 2;
        end else begin
          part_q.push_back(f);
        end
      end else begin
        part_q.push_back(f);
        foreach (part_q[i]) exp_q.push_back(part_q[i]);
        part_q.delete();
        m_pkt++;
        m_mode = 0;
      end
    end else begin
      if (t == 2'b11) m_mode = 0;
      else if (t == 2'b01) begin
        m_err = 1'b1;
        model_head(f, free);
      end
    end
  endtask

  task automatic check_all();
    logic [DW-1:0] h;
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      chk("out_flit", 32'(out_flit), 32'(h));
      chk("out_last", 32'(out_last), 32'(h[DW-1 -: 2] == 2'b11));
    end
    chk("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt % 65536));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic step(input logic [DW-1:0] f, input logic rdy, input logic rv);
    in_flit = f; out_ready = rdy; rst = rv;
    @(posedge clk);
    model_edge(f, rdy, rv);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b1, 1'b1);
  endtask

  // Packet with nbody body flits, payloads base, base+1, ...
  task automatic send_pkt(input int nbody, input logic [7:0] base, input logic rdy);
    step(mk(2'b01, base), rdy, 1'b1);
    for (int i = 0; i < nbody; i++) step(mk(2'b10, base + 8'(i + 1)), rdy, 1'b1);
    step(mk(2'b11, base + 8'(nbody + 1)), rdy, 1'b1);
  endtask

  initial begin
    exp_q.delete(); part_q.delete();
    m_mode = 0; m_pkt = 0; m_drop = 0; m_err = 1'b0;

    // 1: basic packet, streaming out
    do_reset();
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_pkt", 32'(pkt_cnt), 32'd0);
    step(mk(2'b01, 8'd1), 1'b1, 1'b1);
    step(mk(2'b10, 8'd2), 1'b1, 1'b1);
    step(mk(2'b10, 8'd3), 1'b1, 1'b1);
    chk("t1_not_yet_valid", 32'(out_valid), 32'd0);
    step(mk(2'b11, 8'd4), 1'b1, 1'b1);
    chk("t1_valid_after_tail", 32'(out_valid), 32'd1);
    chk("t1_first_flit", 32'(out_flit), 32'h101);
    drain(6);
    chk("t1_pkt", 32'(pkt_cnt), 32'd1);

    // 2: fill the buffer with core stalled; fifth packet dropped
    do_reset();
    for (int p = 0; p < 5; p++) send_pkt(2, 8'(p * 16), 1'b0);
    chk("t2_drop", 32'(drop_cnt), 32'd1);
    chk("t2_valid_held", 32'(out_valid), 32'd1);
    drain(20);
    chk("t2_pkt", 32'(pkt_cnt), 32'd4);
    chk("t2_empty", 32'(out_valid), 32'd0);

    // 3: orphan body/tail, then a good packet
    do_reset();
    step(mk(2'b10, 8'h21), 1'b1, 1'b1);
    step(mk(2'b11, 8'h22), 1'b1, 1'b1);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_pkt0", 32'(pkt_cnt), 32'd0);
    send_pkt(0, 8'h30, 1'b1);
    drain(4);
    chk("t3_pkt1", 32'(pkt_cnt), 32'd1);

    // 4: head inside a packet aborts it
    do_reset();
    step(mk(2'b01, 8'h40), 1'b1, 1'b1);
    step(mk(2'b10, 8'h41), 1'b1, 1'b1);
    send_pkt(1, 8'h50, 1'b1);
    drain(5);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_drop", 32'(drop_cnt), 32'd1);
    chk("t4_pkt", 32'(pkt_cnt), 32'd1);

    // 5: over-length packet
    do_reset();
    step(mk(2'b01, 8'h60), 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(mk(2'b10, 8'(8'h61 + i)), 1'b1, 1'b1);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_drop", 32'(drop_cnt), 32'd1);
    send_pkt(0, 8'h70, 1'b1);
    drain(4);
    chk("t5_pkt", 32'(pkt_cnt), 32'd1);

    // 6: reset with committed packets and a partial one buffered
    do_reset();
    send_pkt(0, 8'h80, 1'b0);
    send_pkt(0, 8'h90, 1'b0);
    step(mk(2'b01, 8'hA0), 1'b0, 1'b1);
    step(mk(2'b10, 8'hA1), 1'b0, 1'b1);
    chk("t6_pre_pkt", 32'(pkt_cnt), 32'd2);
    step('0, 1'b0, 1'b0);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_pkt", 32'(pkt_cnt), 32'd0);
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    send_pkt(0, 8'hB0, 1'b1);
    drain(4);
    chk("t6_pkt1", 32'(pkt_cnt), 32'd1);

    // Random traffic with alternating mostly-ready / mostly-stalled phases.
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      int r;
      logic [1:0] t;
      logic rdy;
      r = int'($urandom_range(0, 99));
      if (r < 15)      t = 2'b00;
      else if (r < 32) t = 2'b01;
      else if (r < 75) t = 2'b10;
      else             t = 2'b11;
      if (((i / 100) % 2) == 1) rdy = ($urandom_range(0, 3) == 0);
      else                       rdy = ($urandom_range(0, 3) != 0);
      step(mk(t, 8'($urandom)), rdy, 1'b1);
    end
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
